// File: rtl/mode_pkg.sv
// Shared definitions for the mode command path: the decoder FSM encoding,
// frame constants, and the mode width that mode_selector also uses.
package mode_pkg;

    // Width of the mode value handed to mode_selector.
    localparam int MODE_W = 2;

    // Frame constants used as parameter defaults by the decoder.
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam logic [3:0] OPCODE_DEFAULT    = 4'h1;

    // Decoder states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CMD    = 3'd1,
        CHK    = 3'd2,
        SETUP  = 3'd3,
        STROBE = 3'd4,
        HOLD   = 3'd5
    } state_t;

    // States in which the decoder is driving or protecting a select pulse.
    function automatic logic is_busy_state(input state_t s);
        return (s == SETUP) || (s == STROBE) || (s == HOLD);
    endfunction

    // States in which a frame is partially received and the inter-byte
    // timeout is armed.
    function automatic logic is_frame_state(input state_t s);
        return (s == CMD) || (s == CHK);
    endfunction

endpackage

// File: rtl/mode_cmd_decoder.sv
// SET_MODE frame parser feeding mode_selector.
// Frame: SYNC_BYTE, command (OPCODE in [7:4], zero in [3:2], mode in [1:0]),
// checksum (SYNC_BYTE ^ command). A good frame updates mode_input, then
// raises select for STROBE_LEN cycles with mode_input stable one cycle
// before, during, and one cycle after the pulse.
module mode_cmd_decoder
    import mode_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter logic [3:0] OPCODE         = OPCODE_DEFAULT,
    parameter int         STROBE_LEN     = 4,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [MODE_W-1:0] mode_input,
    output logic              select,
    output logic              busy,
    output logic              frame_err,
    output logic              timeout_err,
    output logic [7:0]        err_count
);

    // Timeout counter never stores TIMEOUT_CYCLES itself (the limit is acted
    // on as it is reached), but it is sized to hold it.
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    // Strobe counter runs 0 .. STROBE_LEN-1 while in STROBE.
    localparam int SC_W = (STROBE_LEN > 1) ? $clog2(STROBE_LEN) : 1;
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(STROBE_LEN - 1);

    // Registered state.
    state_t            state_q;
    logic [7:0]        cmd_q;
    logic [TO_W-1:0]   to_cnt_q;
    logic [SC_W-1:0]   sc_cnt_q;

    // Next-state values.
    state_t            state_d;
    logic [7:0]        cmd_d;
    logic [TO_W-1:0]   to_cnt_d;
    logic [SC_W-1:0]   sc_cnt_d;
    logic [MODE_W-1:0] mode_d;
    logic              select_d;
    logic              busy_d;
    logic              frame_err_d;
    logic              timeout_err_d;
    logic [7:0]        err_count_d;

    logic              accept;
    logic              cmd_ok;
    logic              chk_ok;
    logic              timeout_hit;

    // rx_ready is the only combinational output: a pure decode of state.
    assign rx_ready = (state_q == IDLE) || (state_q == CMD) || (state_q == CHK);
    assign accept   = rx_valid && rx_ready;

    // Frame field checks against the incoming byte.
    assign cmd_ok = (rx_data[7:4] == OPCODE) && (rx_data[3:2] == 2'b00);
    assign chk_ok = (rx_data == (SYNC_BYTE ^ cmd_q));

    // An accepted byte on the limit edge wins over the timeout.
    assign timeout_hit = is_frame_state(state_q) && !accept && (to_cnt_q == TO_LAST);

    // Next-state and next-output decode.
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        cmd_d         = cmd_q;
        to_cnt_d      = '0;
        sc_cnt_d      = '0;
        mode_d        = mode_input;
        select_d      = select;
        frame_err_d   = 1'b0;
        timeout_err_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Non-sync bytes are dropped without an error.
                if (accept && (rx_data == SYNC_BYTE)) begin
                    state_d = CMD;
                end
            end

            CMD: begin
                if (accept) begin
                    cmd_d = rx_data;
                    if (cmd_ok) begin
                        state_d = CHK;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = IDLE;
                    end
                end else if (timeout_hit) begin
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end

            CHK: begin
                if (accept) begin
                    if (chk_ok) begin
                        mode_d  = cmd_q[MODE_W-1:0];
                        state_d = SETUP;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = IDLE;
                    end
                end else if (timeout_hit) begin
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end

            // mode_input settled last edge; raise select now.
            SETUP: begin
                select_d = 1'b1;
                state_d  = STROBE;
            end

            STROBE: begin
                if (sc_cnt_q == SC_LAST) begin
                    select_d = 1'b0;
                    state_d  = HOLD;
                end else begin
                    sc_cnt_d = sc_cnt_q + SC_W'(1);
                end
            end

            // One quiet cycle after select falls before the next frame.
            HOLD: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = is_busy_state(state_d);

        // frame_err and timeout_err never coincide, so one increment suffices.
        if ((frame_err_d || timeout_err_d) && (err_count != 8'hFF)) begin
            err_count_d = err_count + 8'd1;
        end else begin
            err_count_d = err_count;
        end
    end

    // State and registered-output update; reset aborts any frame or strobe.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed above.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            to_cnt_q    <= '0;
            sc_cnt_q    <= '0;
            mode_input  <= '0;
            select      <= 1'b0;
            busy        <= 1'b0;
            frame_err   <= 1'b0;
            timeout_err <= 1'b0;
            err_count   <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            to_cnt_q    <= to_cnt_d;
            sc_cnt_q    <= sc_cnt_d;
            mode_input  <= mode_d;
            select      <= select_d;
            busy        <= busy_d;
            frame_err   <= frame_err_d;
            timeout_err <= timeout_err_d;
            err_count   <= err_count_d;
        end
    end

endmodule

// File: doc/mode_cmd_decoder.md
Name: mode_cmd_decoder

Overview:
- Upstream stage of mode_selector. Parses SET_MODE command frames from the host byte stream, which is the UART RX byte output.
- Drives mode_selector's mode_input and select pins.
- mode_selector latches on the rising edge of select, so this block keeps mode_input stable one cycle before select rises, for the whole select pulse, and one cycle after it falls.
- Also reports malformed and timed-out frames.

Parameters:
SYNC_BYTE, 8'hA5, first byte of every frame.
OPCODE, 4'h1, required value of the command byte's high nibble.
STROBE_LEN, 4, number of clk cycles select is held high (minimum 1).
TIMEOUT_CYCLES, 1000000, maximum idle clk cycles between bytes inside a frame (minimum 2).

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
rx_data  input  8  incoming byte
rx_valid  input  1  rx_data is valid
rx_ready  output  1  decoder can accept a byte; a byte transfers on a clk edge where rx_valid and rx_ready are both 1
mode_input  output  2  mode value to mode_selector
select  output  1  latch strobe to mode_selector
busy  output  1  high while in SETUP, STROBE or HOLD
frame_err  output  1  one-cycle pulse on a bad command or bad checksum
timeout_err  output  1  one-cycle pulse on inter-byte timeout
err_count  output  8  count of frame_err and timeout_err events, saturates at 255

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - state=IDLE; mode_input=0, which matches mode_selector's reset value;
  - select=0, busy=0, frame_err=0, timeout_err=0, err_count=0;
  - timeout counter=0.
  - This applies mid-frame and mid-strobe too: select drops immediately, with no completion.
- All outputs are registered except rx_ready, which is a combinational decode of state: 1 in IDLE, CMD and CHK; 0 otherwise.
- State machine; "accepted" means rx_valid and rx_ready are both 1 on that edge:
  - IDLE: accepted byte == SYNC_BYTE -> CMD. Any other byte is silently dropped (no error).
  - CMD: accepted byte is latched as cmd.
    - cmd[7:4]==OPCODE and cmd[3:2]==0 -> CHK.
    - Otherwise frame_err pulses -> IDLE.
  - CHK: accepted byte == SYNC_BYTE ^ cmd -> SETUP, and mode_input<=cmd[1:0] on the same edge.
    - Otherwise frame_err pulses -> IDLE; mode_input is unchanged.
  - SETUP: one cycle -> STROBE; select<=1 on that edge.
  - STROBE: select stays high for exactly STROBE_LEN cycles (strobe counter), then select<=0 -> HOLD.
  - HOLD: one cycle -> IDLE. mode_input is held until the next valid frame.
- Latency: if the checksum byte is accepted on edge k, then:
  - mode_input changes at edge k;
  - select rises at edge k+1 and falls at edge k+1+STROBE_LEN;
  - rx_ready returns to 1 after edge k+2+STROBE_LEN.
- Timeout:
  - In CMD and CHK, the counter increments each cycle with no accepted byte and clears on each accepted byte.
  - On reaching TIMEOUT_CYCLES: timeout_err pulses, state -> IDLE, counter clears.
  - If a byte is accepted on the same edge the counter hits the limit, the byte wins and no timeout occurs.
  - The counter is held at 0 in all other states. Its width is $clog2(TIMEOUT_CYCLES+1).
- err_count increments by 1 per error pulse and saturates at 255 (no wrap). frame_err and timeout_err are mutually exclusive by construction.
- A SYNC_BYTE received in CMD or CHK is treated as an ordinary data byte; there is no resync.
- While busy, rx_valid is ignored and the byte stays pending upstream.
- A frame repeating the current mode still produces a full strobe.

Decomposition:
- Shared package mode_pkg holds:
  - the state encoding localparams (IDLE, CMD, CHK, SETUP, STROBE, HOLD);
  - SYNC_BYTE and OPCODE defaults;
  - the MODE_W=2 width constant, also used by mode_selector.
- No sub-module. The timeout and strobe counters are small enough to live inline in a single FSM block.

Test Plan:
- Valid frame: feed A5 12 B7 back-to-back with STROBE_LEN=4. Expect mode_input=2 at the checksum edge k, select high for edges k+1..k+4, and busy/rx_ready=0 during that window. Expect no error pulses.
- Bad checksum (A5 12 00): expect one frame_err pulse, err_count=1, select never rises, mode_input unchanged.
- Bad opcode (A5 22 87): expect frame_err after the second byte and return to IDLE. A following 33 A5 11 B4 yields mode_input=1 plus a strobe; the leading 33 is dropped silently.
- Timeout with TIMEOUT_CYCLES=16: send A5, then hold rx_valid=0 for 16 cycles. Expect a timeout_err pulse and IDLE. A following A5 13 B6 yields mode_input=3 plus a strobe.
- Reset (reset=0) asserted two cycles into STROBE: expect select=0 and mode_input=0 immediately, without waiting for clk. After release, rx_ready=1.
- Back-pressure and saturation:
  - rx_valid held during busy: no byte is consumed until HOLD has passed.
  - 260 bad frames: err_count stops at 255.
